// File: rtl/monitor_prg_pkg.sv
// Shared definitions for the monitor program write port: register map,
// pulse-engine states and STATUS bit positions.
package monitor_prg_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_PULSE_LEN = 2'd1;
  localparam logic [1:0] ADDR_PULSE     = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/monitor_prg_pulse_timer.sv
// Pulse countdown timer: loads a length, counts down while ACTIVE, flags
// expiry and keeps the sticky done flag (set beats clear).
module monitor_prg_pulse_timer
  import monitor_prg_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [LEN_W-1:0] length,
  input  logic             clear_done,
  output logic             expire,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  pulse_state_e     state_r, state_s;
  logic [LEN_W-1:0] cnt_r, cnt_s;
  logic [LEN_W-1:0] eff_len_s;
  logic             done_r, done_s;
  logic             expire_s;

  // Next-state, counter and done-flag logic; a load in the expiry cycle retriggers.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    expire_s = 1'b0;
    eff_len_s = (length == '0) ? LEN_ONE : length;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_s = ACTIVE;
          cnt_s   = eff_len_s;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ACTIVE: begin
        if (load) begin
          cnt_s = eff_len_s;
        end else if (cnt_r == LEN_ONE) begin
          expire_s = 1'b1;
          state_s  = IDLE;
          cnt_s    = '0;
        end else begin
          cnt_s = cnt_r - LEN_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
    if (expire_s) begin
      done_s = 1'b1;
    end else if (clear_done) begin
      done_s = 1'b0;
    end else begin
      done_s = done_r;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
    end
  end

  assign expire = expire_s;
  assign busy   = (state_r == ACTIVE);
  assign done   = done_r;

endmodule

// File: rtl/monitor_prg_wr.sv
// Avalon-MM program write port: DATA output register plus optional timed-pulse
// engine, enabled by defining MONITOR_PRG_WR_PULSE_EN.
module monitor_prg_wr
  import monitor_prg_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             LEN_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [1:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [31:0]      rd_s;
  logic [31:0]      readdata_r;
  logic [WIDTH-1:0] wfield_s;

  assign wr_s     = chipselect & ~write_n;
  assign wfield_s = writedata[WIDTH-1:0];

`ifdef MONITOR_PRG_WR_PULSE_EN
  logic [LEN_W-1:0] len_r;
  logic [WIDTH-1:0] mask_r, mask_s;
  logic             load_s, expire_s, busy_s, done_s, clear_done_s;
  logic             unused_s;

  assign unused_s     = ^writedata[31:LEN_W];
  assign load_s       = wr_s && (address == ADDR_PULSE) && (wfield_s != '0);
  assign clear_done_s = wr_s && (address == ADDR_STATUS) && writedata[STATUS_DONE_BIT];

  monitor_prg_pulse_timer #(.LEN_W(LEN_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .length     (len_r),
    .clear_done (clear_done_s),
    .expire     (expire_s),
    .busy       (busy_s),
    .done       (done_s)
  );

  // DATA/mask update: a DATA write lands first, then the expiring mask is cleared.
  always_comb begin
    data_s = data_r;
    mask_s = mask_r;
    if (wr_s && (address == ADDR_DATA)) begin
      data_s = wfield_s;
    end else begin
      data_s = data_r;
    end
    if (load_s) begin
      data_s = data_s | wfield_s;
      mask_s = mask_r | wfield_s;
    end else if (expire_s) begin
      data_s = data_s & ~mask_r;
      mask_s = '0;
    end else begin
      mask_s = mask_r;
    end
  end

  // Read mux over the four registers, sampled before any same-edge write.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_DATA:      rd_s = {{(32-WIDTH){1'b0}}, data_r};
      ADDR_PULSE_LEN: rd_s = {{(32-LEN_W){1'b0}}, len_r};
      ADDR_PULSE:     rd_s = {{(32-WIDTH){1'b0}}, mask_r};
      ADDR_STATUS: begin
        rd_s[STATUS_BUSY_BIT] = busy_s;
        rd_s[STATUS_DONE_BIT] = done_s;
      end
      default:        rd_s = 32'd0;
    endcase
  end

  // Pulse length and mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_r  <= LEN_W'(1);
      mask_r <= '0;
    end else begin
      if (wr_s && (address == ADDR_PULSE_LEN)) begin
        len_r <= writedata[LEN_W-1:0];
      end
      mask_r <= mask_s;
    end
  end
`else
  logic unused_s;

  assign unused_s = ^writedata[31:WIDTH];

  // DATA update: only DATA writes reach the output port.
  always_comb begin
    if (wr_s && (address == ADDR_DATA)) begin
      data_s = wfield_s;
    end else begin
      data_s = data_r;
    end
  end

  // Read mux: only DATA exists, other addresses read zero.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_DATA: rd_s = {{(32-WIDTH){1'b0}}, data_r};
      default:   rd_s = 32'd0;
    endcase
  end
`endif

  // DATA and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= RESET_VAL;
      readdata_r <= 32'd0;
    end else begin
      data_r     <= data_s;
      readdata_r <= rd_s;
    end
  end

  assign out_port = data_r;
  assign readdata = readdata_r;

endmodule

// File: doc/monitor_prg_wr.md
# monitor_prg_wr

Avalon-MM slave output port for the monitor system; the write-side counterpart of the 8-bit program read port. It holds an 8-bit output register driving `out_port` and adds a timed-pulse engine. The pulse engine sets selected bits and clears them automatically after a programmable number of cycles. It sits on the monitor's Avalon bus next to the read port and drives the target's program/control inputs.

## Interface
- `WIDTH`, 8: width of `out_port` and of the DATA/PULSE fields.
- `LEN_W`, 16: width of the pulse-length register.
- `RESET_VAL`, 0: reset value of the DATA register and `out_port`.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`
- `address`  in  2  word address
- `writedata`  in  32  write data; bits above the field width are ignored
- `readdata`  out  32  registered read data
- `out_port`  out  WIDTH  output port, driven directly from the DATA register

## Operation
- A write occurs on any cycle with `chipselect`=1 and `write_n`=0. Reads need no strobe.
- Register map:
  - Address 0, DATA (RW): writing replaces the DATA register.
  - Address 1, PULSE_LEN (RW, LEN_W bits): pulse length L in cycles. A value of 0 is treated as 1.
  - Address 2, PULSE (W): writing mask M sets DATA |= M, ORs M into the pulse mask, loads the counter with L, and enters ACTIVE. Reading returns the current pulse mask.
  - Address 3, STATUS: bit0 `busy` (read-only, 1 in ACTIVE). bit1 `done` is sticky; writing 1 to bit1 clears it.
- State machine:
  - IDLE → ACTIVE on a PULSE write with M≠0. A PULSE write with M=0 is ignored.
  - ACTIVE: the counter decrements each cycle. When the counter is 1, the next edge clears the pulse-mask bits in DATA, sets `done`, zeroes the mask and returns to IDLE.
  - A PULSE write while ACTIVE retriggers: the new mask is ORed in and the counter reloads with L.
- Simultaneous events:
  - DATA write in the same cycle as pulse expiry: the written value wins, then mask bits are cleared. Result = `writedata` & ~mask.
  - DATA write during ACTIVE without expiry: DATA takes the written value. Mask bits are still cleared at expiry.
  - PULSE write in the expiry cycle: treated as a retrigger. `done` is not set.
  - A `done` clear in the same cycle as a `done` set: set wins.
  - A PULSE_LEN write during ACTIVE affects only later loads.
- `readdata` is zero-extended. Address decode is a mux of the four registers.

## Timing
- Reset values: `readdata`=0, `out_port`=RESET_VAL, pulse mask=0, counter=0, PULSE_LEN=1, `done`=0, state IDLE.
- Reset is asynchronous. Asserting it mid-pulse aborts the pulse immediately.
- A write sampled at edge T appears on `out_port` after edge T (one cycle).
- `readdata` is registered every clock from the current `address`. Read latency is 1 cycle and reflects register state before any same-edge write.
- Pulse bits written at edge T are high on `out_port` for exactly L cycles and cleared at edge T+L. `busy` falls and `done` rises at the same edge.

## Configuration
- Macro `MONITOR_PRG_WR_PULSE_EN`.
- Defined: the full pulse engine and addresses 1–3 are implemented as described above.
- Undefined: only DATA exists; the counter and FSM are not built.
  - Addresses 1–3 read 0 and writes to them are ignored.
  - `out_port` is changed only by DATA writes.

## Structure
- Package `monitor_prg_pkg` holds:
  - address constants `ADDR_DATA`/`ADDR_PULSE_LEN`/`ADDR_PULSE`/`ADDR_STATUS`
  - the pulse-state enum (IDLE, ACTIVE)
  - STATUS bit indices
- Sub-module `monitor_prg_pulse_timer` contains the counter, the FSM and the `done` flag. Its ports are load, length, clear_done, expire, busy and done. It is instantiated only under `MONITOR_PRG_WR_PULSE_EN`.

## Test plan
- Reset with RESET_VAL=0x00, then write DATA=0xA5 → `out_port`=0xA5 one cycle later; read of address 0 returns 0x000000A5 one cycle after `address` is presented.
- PULSE_LEN=4, DATA=0x01, then PULSE=0x80 at edge T → `out_port`=0x81 for exactly 4 cycles, 0x01 from edge T+4; STATUS reads 0x2.
- PULSE_LEN=10, PULSE=0x02, then PULSE=0x04 three cycles later → both bits stay high until 10 cycles after the second write; `done` is set once.
- PULSE_LEN=0 with PULSE=0x10 → bit high for 1 cycle. Writing 0x2 to STATUS then clears `done` (reads 0x0).
- DATA write of 0xFF in the expiry cycle of a 0x0F pulse → `out_port`=0xF0.
- Assert `reset_n` mid-pulse → `out_port`=RESET_VAL asynchronously, `busy`=0; build without the macro → address 2 write ignored and reads 0.
